debug_reg_reader: RTL and testbench
===================================

Name: debug_reg_reader

Overview:
- Host-side consumer of the processor's debug port: drives the register-select input and samples the returned register value and fetch PC.
- On a start pulse, snapshots the PC, sweeps registers 0..NUM_REGS-1, and emits one framed byte stream over a valid/ready interface.
- Sits between the single-cycle computer's debug outputs and a byte sink (UART TX or host FIFO).

Parameters:
- NUM_REGS, 16, registers dumped per frame (1..16).
- SEL_W, 4, width of reg_sel.
- SETTLE_CYCLES, 1, cycles waited after changing reg_sel before sampling reg_data (1..15).
- HDR_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock; all state rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to dump a frame.
- reg_data  in  32  register value returned for reg_sel.
- pc_in  in  32  current fetch PC.
- reg_sel  out  SEL_W  register select driven to the processor debug port.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts a byte.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, reg_sel=0, tx_data=0, tx_valid=0, busy=0, done=0, byte/reg counters=0, checksum=0. Reset mid-frame aborts without completing the frame; no done pulse.
- Transfer rule: a byte transfers on a rising edge with tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid is not deasserted.
- IDLE:
  - start=1 latches pc_in into pc_snap, sets busy=1, sets reg_sel=0, and enters HDR.
  - start is ignored while busy=1.
- HDR: tx_valid=1 with tx_data=HDR_BYTE, asserted in the cycle after start. On transfer, go to PC.
- PC:
  - Sends pc_snap as 4 bytes, big-endian: [31:24] first.
  - A byte counter of 0..3 selects the byte.
  - After the 4th transfer, go to SETTLE with a wait counter of 0.
- SETTLE:
  - tx_valid=0 and reg_sel=current register index.
  - Counts SETTLE_CYCLES cycles, then goes to CAPTURE.
- CAPTURE (1 cycle): latch reg_data into a 32-bit shift buffer and go to SEND.
- SEND:
  - Sends the buffer big-endian as 4 bytes.
  - After the 4th transfer: if reg index = NUM_REGS-1, go to TAIL (or FIN without the feature). Otherwise increment the index, update reg_sel, and go to SETTLE.
- FIN: busy=0 and done=1 for exactly one cycle; return to IDLE with reg_sel=0.
- Frame length is 1 + 4 + 4*NUM_REGS bytes (69 for the defaults), plus 1 with the feature.
- reg_sel holds its value throughout SETTLE, CAPTURE, and SEND for that register.
- Register values are sampled live at CAPTURE time; only the PC is snapshotted at start.
- A start arriving in the same cycle as done is ignored. Start is accepted from IDLE only, at the earliest the cycle after done.
- Minimum frame time with tx_ready held at 1: 1 + 4 + NUM_REGS*(SETTLE_CYCLES+1+4) + 1 cycles.

Optional Feature:
- Macro: DEBUG_READER_CHECKSUM_EN.
- Defined: a running XOR over every transferred byte after the header (PC and register bytes) is kept. State TAIL sends that XOR as a final byte, then goes to FIN. The checksum clears on start.
- Undefined: no TAIL state and no checksum register; SEND goes directly to FIN.

Decomposition:
- Shared package: state encoding enum, HDR_BYTE default, frame-length helper constant, and a byte-select function for a 32-bit big-endian word.
- Natural sub-module: debug_byte_serializer. It loads a 32-bit word and emits 4 bytes big-endian under valid/ready, with an optional running XOR output. It is reused for both the PC and the registers.

Test Plan:
- Basic dump: reset, pc_in=32'h0000_0040, reg_data=32'h1000_0000+reg_sel, tx_ready=1, pulse start. Required stream is A5 00 00 00 40 10 00 00 00 10 00 00 01 … 10 00 00 0F, 69 bytes; done pulses once; busy falls with done.
- Backpressure: toggle tx_ready 1,0,0,1 pseudo-randomly. Required: tx_data stable across every stall, no byte lost or duplicated, and the stream is identical to the basic dump.
- PC snapshot and settle: change pc_in to 32'hDEAD_BEEF one cycle after start. PC bytes are still 00 00 00 40. With SETTLE_CYCLES=3, the value sampled for reg_sel=5 is the value present 3 cycles after reg_sel became 5.
- Start while busy: pulse start at byte 10. No restart occurs, the frame remains 69 bytes, and only one done pulse is produced.
- Async reset mid-frame: deassert reset during SEND of register 7. Outputs go to their reset values immediately. After release, a new start produces a complete, correct frame.
- Checksum (DEBUG_READER_CHECKSUM_EN): with all regs=0 and pc=32'h0000_0040, the final byte is 8'h40 and the frame is 70 bytes. With regs 0..15 = 8'h01..8'h10 in the low byte, the final byte is 8'h40 ^ 8'h10 = 8'h50.

Source files
------------

// File: rtl/debug_reg_reader_pkg.sv
// Shared definitions for the debug register reader: FSM state encoding,
// header byte default, frame-length helper and big-endian byte selection.
// Optional feature macro: DEBUG_READER_CHECKSUM_EN (adds a trailing XOR byte).
package debug_reg_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PC,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SEND,
`ifdef DEBUG_READER_CHECKSUM_EN
    ST_TAIL,
`endif
    ST_FIN
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned NUM_REGS_DEFAULT = 16;

`ifdef DEBUG_READER_CHECKSUM_EN
  localparam int unsigned TAIL_BYTES = 1;
`else
  localparam int unsigned TAIL_BYTES = 0;
`endif

  // Header + 4 PC bytes + 4 bytes per register (+ checksum byte when enabled).
  function automatic int unsigned frame_len(input int unsigned num_regs);
    return 1 + 4 + 4 * num_regs + TAIL_BYTES;
  endfunction

  // Byte idx of a 32-bit word in big-endian order: idx 0 is [31:24].
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_reg_reader_serializer.sv
// debug_byte_serializer: loads a 32-bit word and emits it as 4 bytes,
// most significant first, under valid/ready. A running XOR of every
// transferred byte is kept when DEBUG_READER_CHECKSUM_EN is defined.
module debug_byte_serializer
  import debug_reg_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
`ifdef DEBUG_READER_CHECKSUM_EN
  input  logic        xor_clr_i,
  output logic [7:0]  xor_o,
`endif
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        valid_q;
  logic        fire;

  assign fire    = valid_q & ready_i;
  assign data_o  = byte_sel(word_q, idx_q);
  assign valid_o = valid_q;
  assign last_o  = (idx_q == 2'd3);

  // Word holding register and byte pointer; valid drops after the 4th transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef DEBUG_READER_CHECKSUM_EN
  logic [7:0] xor_q;

  assign xor_o = xor_q;

  // Running XOR over every byte that actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (xor_clr_i) begin
      xor_q <= '0;
    end else if (fire) begin
      xor_q <= xor_q ^ data_o;
    end
  end
`endif

endmodule

// File: rtl/debug_reg_reader.sv
// debug_reg_reader: on start, snapshots the fetch PC, sweeps the processor
// debug port over registers 0..NUM_REGS-1 and streams one framed byte
// sequence (header, PC, registers) over valid/ready.
// Optional feature macro: DEBUG_READER_CHECKSUM_EN (XOR tail byte).
module debug_reg_reader
  import debug_reg_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS      = NUM_REGS_DEFAULT,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  HDR_BYTE      = HDR_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      reg_data,
  input  logic [31:0]      pc_in,
  output logic [SEL_W-1:0] reg_sel,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_REGS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [SEL_W-1:0] reg_sel_q;
  logic [3:0]       wait_q;
  logic [31:0]      pc_snap_q;
  logic             busy_q;
  logic             done_q;

  logic             ser_load;
  logic [31:0]      ser_word;
  logic [7:0]       ser_data;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_fire;
  logic             start_acc;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign ser_fire  = ser_valid && tx_ready;

  // The PC word loads as the header leaves; a register word loads in CAPTURE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    ser_load = 1'b0;
    ser_word = pc_snap_q;
    if ((state_q == ST_HDR) && tx_ready) begin
      ser_load = 1'b1;
    end else if (state_q == ST_CAPTURE) begin
      ser_load = 1'b1;
      ser_word = reg_data;
    end
  end

`ifdef DEBUG_READER_CHECKSUM_EN
  logic [7:0] ser_xor;

  debug_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (ser_load),
    .word_i    (ser_word),
    .ready_i   (tx_ready),
    .xor_clr_i (start_acc),
    .xor_o     (ser_xor),
    .data_o    (ser_data),
    .valid_o   (ser_valid),
    .last_o    (ser_last)
  );
`else
  debug_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .ready_i (tx_ready),
    .data_o  (ser_data),
    .valid_o (ser_valid),
    .last_o  (ser_last)
  );
`endif

  // Frame sequencer: header, PC, then settle/capture/send per register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      reg_sel_q <= '0;
      wait_q    <= '0;
      pc_snap_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_snap_q <= pc_in;
            busy_q    <= 1'b1;
            reg_sel_q <= '0;
            state_q   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            state_q <= ST_PC;
          end
        end
        ST_PC: begin
          if (ser_fire && ser_last) begin
            wait_q  <= '0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // reg_sel is already stable; give the debug port time to respond.
          if (wait_q == SETTLE_LAST) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (ser_fire && ser_last) begin
            if (reg_sel_q == LAST_SEL) begin
`ifdef DEBUG_READER_CHECKSUM_EN
              state_q <= ST_TAIL;
`else
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
`endif
            end else begin
              reg_sel_q <= reg_sel_q + SEL_W'(1);
              wait_q    <= '0;
              state_q   <= ST_SETTLE;
            end
          end
        end
`ifdef DEBUG_READER_CHECKSUM_EN
        ST_TAIL: begin
          if (tx_ready) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          // Start is not looked at here, so a start coincident with done is dropped.
          reg_sel_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte lane mux: header constant, serializer byte, or checksum tail.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state_q)
      ST_HDR: begin
        tx_data  = HDR_BYTE;
        tx_valid = 1'b1;
      end
      ST_PC, ST_SEND: begin
        tx_data  = ser_data;
        tx_valid = ser_valid;
      end
`ifdef DEBUG_READER_CHECKSUM_EN
      ST_TAIL: begin
        tx_data  = ser_xor;
        tx_valid = 1'b1;
      end
`endif
      default: begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
      end
    endcase
  end

  assign reg_sel = reg_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_debug_reg_reader.sv
// Self-checking bench for debug_reg_reader. A frame-level model (expected
// byte queue, byte count, inter-group gaps) is compared with the DUT on
// every falling edge; a slow debug port returns a corrupted value until
// reg_sel has been stable long enough.
`timescale 1ns/1ps
module tb_debug_reg_reader;
  import debug_reg_reader_pkg::*;

  localparam int N    = 16;
  localparam int S    = 3;
  localparam int FLEN = frame_len(N);
  localparam int MAXC = 3000;
`ifdef DEBUG_READER_CHECKSUM_EN
  localparam int LIT_LEN    = 70;
  localparam int LIT_CYCLES = 135;
`else
  localparam int LIT_LEN    = 69;
  localparam int LIT_CYCLES = 134;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] reg_data;
  logic [3:0]  reg_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  debug_reg_reader #(
    .NUM_REGS(N), .SEL_W(4), .SETTLE_CYCLES(S), .HDR_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .reg_data(reg_data),
    .pc_in(pc_in), .reg_sel(reg_sel), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slow debug port: the true value appears only after reg_sel has been
  // stable for more than S cycles; before that it returns the complement.
  logic [31:0] regs [N];
  logic [3:0]  last_sel = 4'd0;
  int          sel_age = 100;

  always @(negedge clk) begin
    if (reg_sel !== last_sel) begin
      last_sel <= reg_sel;
      sel_age  <= 1;
    end else if (sel_age < 100) begin
      sel_age <= sel_age + 1;
    end
  end

  assign reg_data = (sel_age > S) ? regs[reg_sel] : ~regs[reg_sel];

  // Sink backpressure: always ready, or a random 1/0 pattern.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Frame-level model state.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         m_active = 0;
  bit         m_done_due = 0;
  int         m_gap = 0;
  int         m_sent = 0;
  logic [7:0] m_xor = 8'h00;

  function automatic logic [3:0] exp_sel(input int sent);
    int k;
    if (sent < 5) return 4'd0;
    k = (sent - 5) / 4;
    if (k > N - 1) k = N - 1;
    return 4'(k);
  endfunction

  // Compare process: check this cycle, then advance the model across the
  // coming rising edge using the inputs now applied.
  always @(negedge clk) begin
    logic [7:0] b;
    logic [31:0] w;
    if (tx_valid === 1'b1 && tx_ready === 1'b1 && reset === 1'b1)
      rx_q.push_back(tx_data);
    if (!reset) begin
      m_active = 0; m_done_due = 0; m_gap = 0; m_sent = 0;
      exp_q.delete();
      check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_reg_sel", {28'b0, reg_sel}, 32'd0);
      check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    end else begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, (m_active && m_gap == 0)});
      check("busy", {31'b0, busy}, {31'b0, m_active});
      check("done", {31'b0, done}, {31'b0, m_done_due});
      if (m_active)
        check("reg_sel", {28'b0, reg_sel}, {28'b0, exp_sel(m_sent)});
      else if (!m_done_due)
        check("reg_sel_idle", {28'b0, reg_sel}, 32'd0);
      if (m_active && m_gap == 0 && exp_q.size() > 0)
        check("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});

      if (m_done_due) begin
        m_done_due = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_sent = 0; m_gap = 0; m_xor = 8'h00;
          exp_q.delete();
          exp_q.push_back(8'hA5);
          for (int i = 3; i >= 0; i--) exp_q.push_back(8'((pc_in >> (8 * i)) & 32'hFF));
        end
      end else if (m_gap > 0) begin
        if (m_gap == 1) begin
          w = regs[(m_sent - 5) / 4];
          for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
        end
        m_gap--;
      end else if (tx_ready && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        if (m_sent >= 1) m_xor ^= b;
        m_sent++;
        if (m_sent == FLEN) begin
          m_active = 0;
          m_done_due = 1;
        end else if (m_sent >= 5 && (m_sent - 5) % 4 == 0 && m_sent < 5 + 4 * N) begin
          m_gap = S + 1;
        end
`ifdef DEBUG_READER_CHECKSUM_EN
        else if (m_sent == 5 + 4 * N) begin
          exp_q.push_back(m_xor);
        end
`endif
      end
    end
  end

  // One frame: start with pc_first, switch pc_in to pc_after one cycle later,
  // optionally poke start and alter the last register once poke_at bytes are out.
  task automatic run_frame(input logic [31:0] pc_first, input logic [31:0] pc_after,
                           input int poke_at, output int cycles);
    bit got_done = 0;
    bit poked = 0;
    cycles = 0;
    rx_q.delete();
    @(posedge clk); #1;
    pc_in = pc_first;
    start = 1'b1;
    for (int i = 0; i < MAXC && !got_done; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 0) pc_in = pc_after;
      if (poke_at > 0 && !poked && m_sent >= poke_at) begin
        start = 1'b1;
        regs[N-1] = regs[N-1] ^ 32'h0F0F_0000;
        poked = 1;
      end
      @(negedge clk);
      if (busy || done) cycles++;
      if (done) got_done = 1;
    end
    start = 1'b0;
    check("frame_done_seen", {31'b0, got_done}, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic set_regs_basic();
    for (int i = 0; i < N; i++) regs[i] = 32'h1000_0000 + 32'(i);
  endtask

  int cyc;

  initial begin
    set_regs_basic();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_reg_sel", {28'b0, reg_sel}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic dump with tx_ready held high.
    run_frame(32'h0000_0040, 32'h0000_0040, 0, cyc);
    check("basic_len", rx_q.size(), LIT_LEN);
    check("basic_cycles", cyc, LIT_CYCLES);
    if (rx_q.size() >= 69) begin
      check("basic_b0", rx_q[0], 32'hA5);
      check("basic_b4", rx_q[4], 32'h40);
      check("basic_b5", rx_q[5], 32'h10);
      check("basic_b12", rx_q[12], 32'h01);
      check("basic_b68", rx_q[68], 32'h0F);
    end

    // Backpressure: same content under random stalls.
    ready_mode = 1;
    run_frame(32'h0000_0040, 32'h0000_0040, 0, cyc);
    check("bp_len", rx_q.size(), LIT_LEN);
    if (rx_q.size() >= 69) check("bp_b68", rx_q[68], 32'h0F);

    // PC snapshot, start while busy, live sampling of the last register.
    ready_mode = 0;
    run_frame(32'h0000_0040, 32'hDEAD_BEEF, 10, cyc);
    check("snap_len", rx_q.size(), LIT_LEN);
    if (rx_q.size() >= 69) begin
      check("snap_pc", {rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 32'h0000_0040);
      check("live_last", {rx_q[65], rx_q[66], rx_q[67], rx_q[68]}, 32'h1F0F_000F);
    end
    set_regs_basic();

    // Async reset during SEND of register 7.
    @(posedge clk); #1;
    pc_in = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < MAXC && m_sent < 5 + 4 * 7 + 2; i++) @(posedge clk);
    check("reached_reg7", {31'b0, (m_sent >= 5 + 4 * 7 + 2)}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_done", {31'b0, done}, 32'd0);
    check("async_reg_sel", {28'b0, reg_sel}, 32'd0);
    check("async_tx_data", {24'b0, tx_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(32'h0000_0040, 32'h0000_0040, 0, cyc);
    check("post_reset_len", rx_q.size(), LIT_LEN);

`ifdef DEBUG_READER_CHECKSUM_EN
    for (int i = 0; i < N; i++) regs[i] = 32'h0;
    run_frame(32'h0000_0040, 32'h0000_0040, 0, cyc);
    if (rx_q.size() >= 70) check("csum_zero", rx_q[69], 32'h40);
    for (int i = 0; i < N; i++) regs[i] = 32'(i + 1);
    run_frame(32'h0000_0040, 32'h0000_0040, 0, cyc);
    if (rx_q.size() >= 70) check("csum_seq", rx_q[69], 32'h50);
`endif

    // Randomised frames under random backpressure.
    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      run_frame($urandom, $urandom, 0, cyc);
      check("rand_len", rx_q.size(), LIT_LEN);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
